spi_slave_rx: RTL

- SPI mode-0 slave receiver: the far end of the team's SPI master link (sck/cs/mosi).
- Oversamples sck, cs and mosi in the clk_50m domain and deserialises MSB-first bytes.
- Presents each byte through a one-deep holding register with valid/ack handshake.
- Flags overrun and truncated-frame errors.
- Sits on the FPGA bare-metal SoC side, feeding a byte consumer (UART bridge or register file).

---
 rtl/spi_slave_rx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_slave_rx
// Brief    : SPI mode-0 slave receiver; oversampled sck/cs/mosi, MSB-first
//            deserialiser with a one-deep valid/ack holding register.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  state_t                 r_state;
  state_t                 w_state_nxt;
  // Only the DATA_W-1 earlier bits are stored; the final bit comes straight
  // from the synchroniser when the frame completes.
  logic [DATA_W-2:0]      r_shifter;
  logic [DATA_W-2:0]      w_shifter_nxt;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [CNT_W-1:0]       w_bit_cnt_nxt;

  logic                   w_sck_s;
  logic                   w_cs_s;
  logic                   w_mosi_s;
  logic                   w_sck_rise;
  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic [DATA_W-1:0]      w_byte;
  logic                   w_frame_done;
  logic                   w_frame_err;
  logic                   w_load;
  logic                   w_overrun;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sck_d     <= w_sck_s;
      r_cs_d      <= w_cs_s;
    end
  end

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_cs_rise  = w_cs_s & ~r_cs_d;
  assign w_cs_fall  = ~w_cs_s & r_cs_d;
  assign w_byte     = {r_shifter, w_mosi_s};

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shifter <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shifter <= w_shifter_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shifter_nxt = r_shifter;
    w_bit_cnt_nxt = r_bit_cnt;
    w_frame_done  = 1'b0;
    w_frame_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt   = SHIFT;
          w_shifter_nxt = '0;
          w_bit_cnt_nxt = '0;
        end
      end
      SHIFT: begin
        if (w_sck_rise) begin
          w_shifter_nxt = w_byte[DATA_W-2:0];
          if (r_bit_cnt == C_LAST_BIT) begin
            w_frame_done  = 1'b1;
            w_bit_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
        // A completion in the same cycle has already cleared the count,
        // so only a genuinely partial frame raises the error.
        if (w_cs_rise) begin
          w_state_nxt   = IDLE;
          w_frame_err   = (w_bit_cnt_nxt != C_CNT_ZERO);
          w_bit_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_bit_cnt_nxt = '0;
      end
    endcase
  end

  assign w_load    = w_frame_done & (~rx_valid | rx_ack);
  assign w_overrun = w_frame_done & rx_valid & ~rx_ack;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= w_overrun;
      frame_err <= w_frame_err;
      if (w_load) begin
        rx_data  <= w_byte;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (r_state == SHIFT);

endmodule
`default_nettype wire
